// File: rtl/login_ctrl.sv
// Login-mode controller: collects ID digits from button pulses, checks them against a
// stored ID, counts failed attempts and enforces a timed lockout.
module login_ctrl #(
    parameter int unsigned               NUM_DIGITS  = 4,
    parameter logic [NUM_DIGITS*4-1:0]   USER_ID     = 16'h1234,
    parameter int unsigned               MAX_TRIES   = 3,
    parameter int unsigned               LOCK_CYCLES = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] digit_in,
    input  logic       enter_p,
    input  logic       logout_p,
    output logic       logged_in,
    output logic       fail,
    output logic       locked,
    output logic [2:0] digit_cnt,
    output logic [2:0] tries_left
);

    localparam logic [2:0] StEntry   = 3'd0;
    localparam logic [2:0] StCheck   = 3'd1;
    localparam logic [2:0] StGranted = 3'd2;
    localparam logic [2:0] StDenied  = 3'd3;
    localparam logic [2:0] StLocked  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  digit_cnt_q, digit_cnt_d;
    logic        mismatch_q, mismatch_d;
    logic [2:0]  fails_q, fails_d;
    logic [31:0] lock_cnt_q, lock_cnt_d;

    logic [NUM_DIGITS*4-1:0] id_shifted;
    logic [3:0]              exp_digit;

    // Digit 0 is the most-significant nibble of USER_ID.
    assign id_shifted = USER_ID >> (4 * (NUM_DIGITS - 1 - 32'(digit_cnt_q)));
    assign exp_digit  = id_shifted[3:0];

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        mismatch_d  = mismatch_q;
        fails_d     = fails_q;
        lock_cnt_d  = lock_cnt_q;
        case (state_q)
            StEntry: begin
                if (logout_p) begin
                    digit_cnt_d = 3'd0;
                    mismatch_d  = 1'b0;
                end else if (enter_p) begin
                    // No early abort: every attempt takes the full digit count.
                    mismatch_d = mismatch_q | (digit_in != exp_digit);
                    if (32'(digit_cnt_q) == NUM_DIGITS - 1) begin
                        digit_cnt_d = 3'd0;
                        state_d     = StCheck;
                    end else begin
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end
            end
            StCheck: begin
                mismatch_d = 1'b0;
                if (!mismatch_q) begin
                    state_d = StGranted;
                    fails_d = 3'd0;
                end else if (32'(fails_q) + 1 >= MAX_TRIES) begin
                    state_d    = StLocked;
                    fails_d    = 3'(MAX_TRIES);
                    lock_cnt_d = 32'd0;
                end else begin
                    state_d = StDenied;
                    fails_d = fails_q + 3'd1;
                end
            end
            StDenied: state_d = StEntry;
            StGranted: begin
                if (logout_p) state_d = StEntry;
            end
            StLocked: begin
                if (lock_cnt_q == LOCK_CYCLES - 1) begin
                    state_d    = StEntry;
                    fails_d    = 3'd0;
                    lock_cnt_d = 32'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d     = StEntry;
                digit_cnt_d = 3'd0;
                mismatch_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StEntry;
            digit_cnt_q <= 3'd0;
            mismatch_q  <= 1'b0;
            fails_q     <= 3'd0;
            lock_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            mismatch_q  <= mismatch_d;
            fails_q     <= fails_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    assign logged_in  = (state_q == StGranted);
    assign fail       = (state_q == StDenied);
    assign locked     = (state_q == StLocked);
    assign digit_cnt  = digit_cnt_q;
    assign tries_left = 3'(MAX_TRIES) - fails_q;

endmodule

// File: tb/tb_login_ctrl.sv
// Directed bench for login_ctrl: login, rejection, lockout, logout/abort and async reset.
module tb_login_ctrl;

    logic       CLK;
    logic       RST;
    logic [3:0] digit_in;
    logic       enter_p;
    logic       logout_p;
    logic       logged_in;
    logic       fail;
    logic       locked;
    logic [2:0] digit_cnt;
    logic [2:0] tries_left;

    int checks   = 0;
    int failures = 0;

    login_ctrl #(
        .NUM_DIGITS (4),
        .USER_ID    (16'h1234),
        .MAX_TRIES  (3),
        .LOCK_CYCLES(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .digit_in  (digit_in),
        .enter_p   (enter_p),
        .logout_p  (logout_p),
        .logged_in (logged_in),
        .fail      (fail),
        .locked    (locked),
        .digit_cnt (digit_cnt),
        .tries_left(tries_left)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_in = d;
        enter_p  = 1'b1;
        tick();
        enter_p  = 1'b0;
    endtask

    task automatic attempt(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) begin
            press(code[i*4 +: 4]);
        end
    endtask

    task automatic logout();
        logout_p = 1'b1;
        tick();
        logout_p = 1'b0;
    endtask

    initial begin
        RST = 1'b0; digit_in = 4'd0; enter_p = 1'b0; logout_p = 1'b0;
        #12;
        chk("rst_logged_in", {7'd0, logged_in}, 8'd0);
        chk("rst_fail", {7'd0, fail}, 8'd0);
        chk("rst_locked", {7'd0, locked}, 8'd0);
        chk("rst_digit_cnt", {5'd0, digit_cnt}, 8'd0);
        chk("rst_tries", {5'd0, tries_left}, 8'd3);
        RST = 1'b1;
        tick();

        // Correct login
        press(4'h1); chk("ok_cnt1", {5'd0, digit_cnt}, 8'd1);
        press(4'h2); chk("ok_cnt2", {5'd0, digit_cnt}, 8'd2);
        press(4'h3); chk("ok_cnt3", {5'd0, digit_cnt}, 8'd3);
        press(4'h4); chk("ok_cnt0", {5'd0, digit_cnt}, 8'd0);
        chk("ok_check_not_yet", {7'd0, logged_in}, 8'd0);
        tick();
        chk("ok_logged_in", {7'd0, logged_in}, 8'd1);
        chk("ok_tries", {5'd0, tries_left}, 8'd3);
        chk("ok_fail", {7'd0, fail}, 8'd0);
        tick();
        chk("ok_hold", {7'd0, logged_in}, 8'd1);

        // enter_p and logout_p together in GRANTED: logout wins
        digit_in = 4'h1; enter_p = 1'b1; logout_p = 1'b1;
        tick();
        enter_p = 1'b0; logout_p = 1'b0;
        chk("both_logout", {7'd0, logged_in}, 8'd0);
        chk("both_cnt", {5'd0, digit_cnt}, 8'd0);

        // Wrong ID
        attempt(16'h1235);
        chk("wr_check_fail0", {7'd0, fail}, 8'd0);
        tick();
        chk("wr_fail_pulse", {7'd0, fail}, 8'd1);
        chk("wr_tries", {5'd0, tries_left}, 8'd2);
        tick();
        chk("wr_fail_drop", {7'd0, fail}, 8'd0);
        chk("wr_cnt", {5'd0, digit_cnt}, 8'd0);
        chk("wr_logged_in", {7'd0, logged_in}, 8'd0);

        // Recovery after failure
        attempt(16'h1234);
        tick();
        chk("rec_logged_in", {7'd0, logged_in}, 8'd1);
        chk("rec_tries", {5'd0, tries_left}, 8'd3);
        logout();
        chk("rec_logout", {7'd0, logged_in}, 8'd0);

        // Abort mid-entry with one failure recorded
        attempt(16'h9999);
        tick();
        chk("ab_fail", {7'd0, fail}, 8'd1);
        tick();
        press(4'h1);
        press(4'h2);
        chk("ab_cnt2", {5'd0, digit_cnt}, 8'd2);
        logout();
        chk("ab_cnt0", {5'd0, digit_cnt}, 8'd0);
        chk("ab_tries", {5'd0, tries_left}, 8'd2);

        // Second failure, then third triggers lockout
        attempt(16'h9999);
        tick();
        chk("lk_fail2", {7'd0, fail}, 8'd1);
        chk("lk_tries1", {5'd0, tries_left}, 8'd1);
        tick();
        attempt(16'h9999);
        chk("lk_check", {7'd0, locked}, 8'd0);
        tick();
        chk("lk_locked", {7'd0, locked}, 8'd1);
        chk("lk_no_fail", {7'd0, fail}, 8'd0);
        chk("lk_tries0", {5'd0, tries_left}, 8'd0);
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) press(4'h1);
            else if (i == 5) logout();
            else tick();
            chk($sformatf("lk_hold%0d", i), {7'd0, locked}, 8'd1);
            chk($sformatf("lk_cnt%0d", i), {5'd0, digit_cnt}, 8'd0);
        end
        tick();
        chk("lk_release", {7'd0, locked}, 8'd0);
        chk("lk_tries3", {5'd0, tries_left}, 8'd3);
        chk("lk_entry_cnt", {5'd0, digit_cnt}, 8'd0);

        // Async reset mid-entry
        press(4'h1);
        press(4'h2);
        chk("ar_cnt2", {5'd0, digit_cnt}, 8'd2);
        #3 RST = 1'b0;
        #1;
        chk("ar_cnt0", {5'd0, digit_cnt}, 8'd0);
        chk("ar_tries", {5'd0, tries_left}, 8'd3);
        RST = 1'b1;
        tick();

        // Async reset mid-lockout
        attempt(16'h9999); tick(); tick();
        attempt(16'h9999); tick(); tick();
        attempt(16'h9999); tick();
        chk("ar_locked", {7'd0, locked}, 8'd1);
        tick(); tick();
        #3 RST = 1'b0;
        #1;
        chk("ar_unlocked", {7'd0, locked}, 8'd0);
        chk("ar_lk_tries", {5'd0, tries_left}, 8'd3);
        chk("ar_lk_logged", {7'd0, logged_in}, 8'd0);
        RST = 1'b1;
        tick();

        attempt(16'h1234);
        tick();
        chk("ar_login", {7'd0, logged_in}, 8'd1);
        chk("ar_login_tries", {5'd0, tries_left}, 8'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
